lagarto_plic_target_claim: RTL

- Per-target back end of the PLIC. Consumes the winning {priority, ID} from the priority-comparison tree and compares it against the target's threshold to drive the external interrupt pending line.
- Services claim reads and completion writes from the target register interface.
- Returns one-hot claim/complete pulses to the per-source gateways and tracks which sources are in flight.

---
 rtl/lagarto_plic_target_claim.sv | 77 +++++++
 1 files changed

// File: rtl/lagarto_plic_target_claim.sv
// Per-target PLIC back end: threshold compare for the EIP line, claim/complete
// handshakes with the target register interface, and in-flight source tracking.
module lagarto_plic_target_claim #(
  parameter int NUM_SOURCES    = 31,
  parameter int PRIORITY_WIDTH = 3,
  parameter int ID_WIDTH       = $clog2(NUM_SOURCES+1)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [PRIORITY_WIDTH-1:0] maximum_priority_i,
  input  logic [ID_WIDTH-1:0]       maximum_id_i,
  input  logic [PRIORITY_WIDTH-1:0] priority_threshold_i,
  input  logic                      claim_request_i,
  output logic                      claim_ack_o,
  output logic [ID_WIDTH-1:0]       claim_id_o,
  input  logic                      complete_request_i,
  input  logic [ID_WIDTH-1:0]       complete_id_i,
  output logic                      complete_ack_o,
  output logic [NUM_SOURCES:0]      source_claim_o,
  output logic [NUM_SOURCES:0]      source_complete_o,
  output logic [NUM_SOURCES:0]      in_flight_o,
  output logic                      external_interrupt_o
);

  typedef enum logic {IDLE, CLAIM} state_t;

  localparam logic [NUM_SOURCES:0] ONE = {{NUM_SOURCES{1'b0}}, 1'b1};

  state_t               state;
  logic                 claim_take;
  logic                 cand_valid;
  logic                 complete_hit;
  logic                 eip_next;
  logic [NUM_SOURCES:0] claim_mask;
  logic [NUM_SOURCES:0] complete_mask;

  always_comb begin
    claim_take    = (state == IDLE) && claim_request_i;
    cand_valid    = (maximum_id_i != '0) && (int'(maximum_id_i) <= NUM_SOURCES);
    claim_mask    = ONE << maximum_id_i;
    complete_mask = ONE << complete_id_i;
    complete_hit  = complete_request_i && (complete_id_i != '0) &&
                    (int'(complete_id_i) <= NUM_SOURCES) &&
                    ((in_flight_o & complete_mask) != '0);
    // EIP drops for the claim cycle so the hart sees the claim before a re-raise
    eip_next      = (maximum_id_i != '0) &&
                    (maximum_priority_i > priority_threshold_i) && !claim_take;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state                <= IDLE;
      claim_ack_o          <= 1'b0;
      claim_id_o           <= '0;
      complete_ack_o       <= 1'b0;
      source_claim_o       <= '0;
      source_complete_o    <= '0;
      in_flight_o          <= '0;
      external_interrupt_o <= 1'b0;
    end else begin
      state          <= claim_take ? CLAIM : IDLE;
      claim_ack_o    <= claim_take;
      complete_ack_o <= complete_request_i;
      if (claim_take) begin
        claim_id_o     <= cand_valid ? maximum_id_i : '0;
        source_claim_o <= cand_valid ? claim_mask : '0;
      end else begin
        source_claim_o <= '0;
      end
      source_complete_o <= complete_hit ? complete_mask : '0;
      // The claim pulse of this cycle lands in the bitmap on the next edge; set beats clear
      in_flight_o <= (in_flight_o & ~(complete_hit ? complete_mask : '0)) | source_claim_o;
      external_interrupt_o <= eip_next;
    end
  end

endmodule
